// File: rtl/fifo_mc_if.sv
// Handshake and status bundle between a sample producer/consumer and fifo_mc.
// The master drives the requests. The slave (the FIFO) returns data, flags and occupancy.
interface fifo_mc_if #(
    parameter int DWIDTH = 24,
    parameter int NCH    = 2,
    parameter int AW     = 2
);
    logic                    flush;
    logic                    wr;
    logic                    rd;
    logic                    err_clr;
    logic [NCH*DWIDTH-1:0]   wdata;
    logic [NCH*DWIDTH-1:0]   rdata;
    logic                    empty;
    logic                    full;
    logic                    almost_empty;
    logic                    almost_full;
    logic [AW:0]             count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output flush, wr, rd, err_clr, wdata,
        input  rdata, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  flush, wr, rd, err_clr, wdata,
        output rdata, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mc.sv
// Multi-channel show-ahead sample FIFO. All lanes share one pointer pair.
// Status flags are registered from the next occupancy, so they never depend on pointer equality.
module fifo_mc #(
    parameter int DWIDTH = 24,
    parameter int NCH    = 2,
    parameter int AW     = 2,
    parameter int AF_LVL = 3,
    parameter int AE_LVL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    fifo_mc_if.slave   bus
);
    localparam int          DEPTH = 1 << AW;
    localparam int          W     = NCH * DWIDTH;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_V    = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_V    = (AW+1)'(AE_LVL);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          empty_r;
    logic          full_r;
    logic          almost_empty_r;
    logic          almost_full_r;
    logic          overflow_r;
    logic          underflow_r;

    logic          rd_acc_s;
    logic          w_acc_s;
    logic [AW:0]   count_next_s;
    logic          ovf_set_s;
    logic          udf_set_s;

    // Accepted read/write and next occupancy; a full FIFO still takes a write when a pop frees a slot
    always_comb begin
        rd_acc_s = bus.rd & ~empty_r;
        w_acc_s  = bus.wr & (~full_r | rd_acc_s);
        if (bus.flush) begin
            count_next_s = {(AW+1){1'b0}};
        end else begin
            case ({w_acc_s, rd_acc_s})
                2'b10:   count_next_s = count_r + (AW+1)'(1'b1);
                2'b01:   count_next_s = count_r - (AW+1)'(1'b1);
                default: count_next_s = count_r;
            endcase
        end
        ovf_set_s = bus.wr & full_r & ~bus.rd & ~bus.flush;
        udf_set_s = bus.rd & empty_r & ~bus.flush;
    end

    // Sample storage; deliberately not reset
    always_ff @(posedge clk) begin
        if (w_acc_s && !bus.flush) begin
            mem_r[wr_ptr_r] <= bus.wdata;
        end
    end

    // Pointers, occupancy, flags and sticky errors (errors survive flush, err_clr wins over a set)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= {AW{1'b0}};
            rd_ptr_r       <= {AW{1'b0}};
            count_r        <= {(AW+1){1'b0}};
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_empty_r <= 1'b1;
            almost_full_r  <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (w_acc_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                end
                if (rd_acc_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
            end
            count_r        <= count_next_s;
            empty_r        <= (count_next_s == {(AW+1){1'b0}});
            full_r         <= (count_next_s == DEPTH_V);
            almost_empty_r <= (count_next_s <= AE_V);
            almost_full_r  <= (count_next_s >= AF_V);
            if (bus.err_clr) begin
                overflow_r  <= 1'b0;
                underflow_r <= 1'b0;
            end else begin
                overflow_r  <= overflow_r | ovf_set_s;
                underflow_r <= underflow_r | udf_set_s;
            end
        end
    end

    assign bus.rdata        = mem_r[rd_ptr_r];
    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule
